// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W bits MSB-first, optional even parity (RX_PARITY_EN), stop bit.
// Word valid 1 cycle after stop sample; holds on out_ready=0, new frames then dropped as sticky overrun.
module serial_frame_receiver #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clock,
    input  logic              resetp,
    input  logic              bit_in,
    input  logic              bit_en,
    input  logic              out_ready,
    input  logic              clr_err,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_frame_err;
    logic              r_overrun;
`ifdef RX_PARITY_EN
    logic              r_par_bit;
`endif

    logic w_stop_smp;
    logic w_par_ok;
    logic w_good;
    logic w_last;
    logic w_ovr_set;

    assign w_stop_smp = bit_en & (r_state == ST_STOP);
`ifdef RX_PARITY_EN
    assign w_par_ok   = ~(^r_shift ^ r_par_bit);
`else
    assign w_par_ok   = 1'b1;
`endif
    assign w_good     = w_stop_smp & ~bit_in & w_par_ok;
    assign w_last     = (r_bit_cnt == CNT_W'(DATA_W - 1));
    // A completed frame only collides with a pending word the consumer is not taking this cycle.
    assign w_ovr_set  = w_good & r_out_valid & ~out_ready;

    always_ff @(posedge clock) begin
        if (resetp) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef RX_PARITY_EN
            r_par_bit   <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            if (bit_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (bit_in) r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        r_shift <= {r_shift[DATA_W-2:0], bit_in};
                        if (w_last) begin
                            r_bit_cnt <= '0;
`ifdef RX_PARITY_EN
                            r_state   <= ST_PARITY;
`else
                            r_state   <= ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
`ifdef RX_PARITY_EN
                        r_par_bit <= bit_in;
`endif
                        r_state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        // A 1 in the stop slot is an error, never a fresh start bit.
                        r_frame_err <= bit_in | ~w_par_ok;
                        r_state     <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            if (w_good && (!r_out_valid || out_ready)) begin
                r_out_data  <= r_shift;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_ovr_set)    r_overrun <= 1'b1;
            else if (clr_err) r_overrun <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

endmodule
